ptm_param_matcher: RTL and testbench
====================================

// Module: ptm_param_matcher
// PURPOSE
//  Parametrised successor of the lab3 pattern-matching block. Streams a bit sequence out of a
//  synchronous-read memory and counts occurrences of a run-time programmable pattern of
//  1..PAT_MAX bits. Overlapping or non-overlapping counting is selectable.
//  The block sits between the top-level control (start/fin/result) and the stream RAM (en/addr/data).
// PARAMETERS
//  ADDR_W   10  memory address width; stream length L <= 2**ADDR_W-1
//  DATA_W   10  memory word width; the word at addr 0 holds L, stream bit = data[0]
//  PAT_MAX  16  maximum pattern length, >= 2
//  CNT_W    10  match counter width; the counter saturates
// PORTS
//  clk      in   1               rising-edge clock
//  rst      in   1               asynchronous reset, active-high
//  start    in   1               request; sampled in IDLE/DONE only
//  pat      in   PAT_MAX         pattern; pat[pat_len-1] = earliest bit; captured at start
//  pat_len  in   $clog2(PAT_MAX+1)  pattern length; captured at start
//  overlap  in   1               1 = overlapping count, 0 = non-overlapping; captured at start
//  en       out  1               memory read enable (registered)
//  addr     out  ADDR_W          memory read address (registered)
//  data     in   DATA_W          read data; valid the cycle after en/addr
//  flag     out  1               1-cycle pulse per counted match (registered)
//  busy     out  1               high from the cycle after start until fin
//  fin      out  1               1-cycle pulse; result is final
//  result   out  CNT_W           match count; holds after fin until the next accepted start
//  err      out  1               pat_len==0 or pat_len>PAT_MAX on the last start; held with result
// BEHAVIOUR
//  Reset: state=IDLE; en, addr, flag, busy, fin, result, err, window, hist, count all 0.
//   rst mid-operation aborts at once; no fin is issued.
//  FSM: IDLE -> LREQ -> LWAIT -> SCAN -> DRAIN -> DONE -> (IDLE | LREQ).
//   IDLE/DONE: start=1 captures pat/pat_len/overlap and clears count/err/hist/window.
//     If pat_len is illegal: err=1, result=0, fin pulses next cycle, go DONE. No memory access.
//     Otherwise go LREQ with en=1, addr=0.
//   LREQ: go LWAIT (en=0). LWAIT: L = min(data, 2**ADDR_W-1).
//     If L==0: fin next cycle, result=0. Else go SCAN with en=1, addr=1.
//   SCAN: issue addr k=1..L, one per cycle, en=1; after addr=L go DRAIN (en=0).
//   Data path: each returned bit shifts into window (LSB = newest). hist counts received bits,
//     saturating at pat_len. match = (hist==pat_len) && ((window ^ pat) & mask)==0,
//     where mask = (1<<pat_len)-1.
//   On match: flag=1 next cycle and count += 1, saturating at 2**CNT_W-1.
//     If overlap=0, hist is also cleared, so bits are never shared between matches.
//  Timing (cycle 0 = start sampled): en/addr=0 in cycle 1; addr k in cycle k+2;
//   bit k in window at cycle k+4; its flag in cycle k+5; fin and final result in cycle L+6.
//  DONE: fin=1 for exactly one cycle on entry; busy=0. start in the same cycle as fin is
//   accepted. start while busy is ignored. pat/pat_len/overlap changes while busy are ignored.
//  result tracks count during the scan but is only guaranteed valid when fin=1.
// STRUCTURE
//  Package ptm_pkg: state enum (IDLE, LREQ, LWAIT, SCAN, DRAIN, DONE); function
//   plen_w(PAT_MAX)=$clog2(PAT_MAX+1); saturating-increment function.
//  Sub-module ptm_window_cmp: shift window, hist counter, mask generation, match output.
//   The top level holds the FSM, address counter, count, and the flag/fin/result registers.
// TESTING
//  pat=7'b1101001, len 7, overlap=1, stream 1101001101001 (L=13)
//   -> 2 flags, result=2, fin at cycle 19.
//  pat=4'b1101, stream 1101101 (L=7): overlap=1 -> result=2; overlap=0 -> result=1.
//  pat_len=0, and pat_len=PAT_MAX+1 -> no en asserted, err=1, result=0, fin at cycle 1.
//  L=0 in mem[0] -> only addr 0 read, result=0, fin at cycle 3.
//   With ADDR_W=4 and mem[0]=100, L clamps to 15 and addr stops at 15.
//  CNT_W=2, pat=1'b1 (pat_len=1), stream of 6 ones -> 6 flags, result saturates at 3.
//  rst asserted at addr=5 -> all outputs 0 immediately, no fin.
//   start pulsed while busy -> ignored; back-to-back start on the fin cycle -> a new run with fresh count.

Source files
------------

// File: rtl/ptm_pkg.sv
// Shared types and helpers for the parametrised pattern matcher.
// Holds the FSM state encoding, the pattern-length width rule and a saturating increment.
package ptm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LREQ  = 3'd1,
        LWAIT = 3'd2,
        SCAN  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int plen_w(input int pat_max);
        return $clog2(pat_max + 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/ptm_window_cmp.sv
// Shift window of received stream bits with a fill counter (hist) and masked pattern compare.
// match is only raised in the cycle right after a new bit entered the window.
module ptm_window_cmp
    import ptm_pkg::*;
#(
    parameter int PAT_MAX = 16,
    parameter int PLEN_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pat,
    input  logic [PLEN_W-1:0]  pat_len,
    input  logic               overlap,
    output logic               match
);

    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] mask;
    logic [PLEN_W-1:0]  hist;
    logic               new_bit;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (32'(i) < 32'(pat_len));
        end
    end

    assign match = new_bit && (hist == pat_len) && (((window ^ pat) & mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window  <= '0;
            hist    <= '0;
            new_bit <= 1'b0;
        end else if (clr) begin
            window  <= '0;
            hist    <= '0;
            new_bit <= 1'b0;
        end else begin
            new_bit <= shift;
            if (shift) begin
                window <= {window[PAT_MAX-2:0], bit_in};
            end
            // A non-overlapping match consumes its bits; a bit arriving on the same edge starts the next window.
            if (match && !overlap) begin
                hist <= shift ? PLEN_W'(1) : '0;
            end else if (shift) begin
                hist <= PLEN_W'(sat_inc(32'(hist), 32'(pat_len)));
            end
        end
    end

endmodule

// File: rtl/ptm_param_matcher.sv
// Streams L bits out of a synchronous-read RAM (L stored at addr 0) and counts matches of a
// run-time programmable pattern, overlapping or not. FSM, address counter and result registers live here.
module ptm_param_matcher
    import ptm_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 10,
    parameter int PAT_MAX = 16,
    parameter int CNT_W   = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PAT_MAX-1:0]           pat,
    input  logic [plen_w(PAT_MAX)-1:0]   pat_len,
    input  logic                         overlap,
    output logic                         en,
    output logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            data,
    output logic                         flag,
    output logic                         busy,
    output logic                         fin,
    output logic [CNT_W-1:0]             result,
    output logic                         err,
    output state_t                       dbg_state
);

    localparam int PLEN_W   = plen_w(PAT_MAX);
    localparam int ADDR_MAX = (1 << ADDR_W) - 1;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    // Memory handshake: en/addr are registered; data for a read is valid exactly one cycle later.
    state_t              state, state_d;
    logic                en_d, fin_d, busy_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W-1:0]   len_q, l_clamp;
    logic [PAT_MAX-1:0]  pat_q;
    logic [PLEN_W-1:0]   plen_q;
    logic                ovl_q;
    logic                dv;
    logic [1:0]          drain_cnt;
    logic [CNT_W-1:0]    count;
    logic                start_ok, len_ok, shift, match;

    assign dbg_state = state;
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign len_ok    = (pat_len != '0) && (32'(pat_len) <= 32'(PAT_MAX));
    assign shift     = dv && ((state == SCAN) || (state == DRAIN));

    always_comb begin
        l_clamp = ADDR_W'(data);
        if (32'(data) > 32'(ADDR_MAX)) begin
            l_clamp = ADDR_W'(ADDR_MAX);
        end
    end

    always_comb begin
        state_d = state;
        en_d    = 1'b0;
        addr_d  = addr;
        fin_d   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (!len_ok) begin
                        state_d = DONE;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = LREQ;
                        en_d    = 1'b1;
                        addr_d  = '0;
                    end
                end else if (state == DONE) begin
                    state_d = IDLE;
                end
            end
            LREQ:  state_d = LWAIT;
            LWAIT: begin
                if (l_clamp == '0) begin
                    state_d = DONE;
                    fin_d   = 1'b1;
                end else begin
                    state_d = SCAN;
                    en_d    = 1'b1;
                    addr_d  = ADDR_W'(1);
                end
            end
            SCAN: begin
                if (addr == len_q) begin
                    state_d = DRAIN;
                end else begin
                    en_d   = 1'b1;
                    addr_d = addr + ADDR_W'(1);
                end
            end
            // Three cycles cover read latency, window load and the final flag/count update.
            DRAIN: begin
                if (drain_cnt == 2'd2) begin
                    state_d = DONE;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LREQ) || (state_d == LWAIT) || (state_d == SCAN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en        <= 1'b0;
            addr      <= '0;
            fin       <= 1'b0;
            busy      <= 1'b0;
            flag      <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            count     <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            plen_q    <= '0;
            ovl_q     <= 1'b0;
            dv        <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_d;
            en        <= en_d;
            addr      <= addr_d;
            fin       <= fin_d;
            busy      <= busy_d;
            dv        <= en;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (state == LWAIT) begin
                len_q <= l_clamp;
            end
            if (start_ok) begin
                pat_q  <= pat;
                plen_q <= pat_len;
                ovl_q  <= overlap;
                err    <= !len_ok;
                count  <= '0;
                result <= '0;
                flag   <= 1'b0;
            end else begin
                flag   <= match;
                result <= count;
                if (match) begin
                    count <= CNT_W'(sat_inc(32'(count), 32'(CNT_MAX)));
                end
            end
        end
    end

    ptm_window_cmp #(
        .PAT_MAX (PAT_MAX),
        .PLEN_W  (PLEN_W)
    ) u_win (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .shift   (shift),
        .bit_in  (data[0]),
        .pat     (pat_q),
        .pat_len (plen_q),
        .overlap (ovl_q),
        .match   (match)
    );

endmodule

// File: tb/tb_ptm_param_matcher.sv
// Directed bench for ptm_param_matcher: a default instance plus a small one (ADDR_W=4, CNT_W=2)
// for length clamping and counter saturation, each fed by its own synchronous-read memory.
module tb_ptm_param_matcher;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start1 = 1'b0, ovl1 = 1'b0;
    logic [15:0] pat1 = '0;
    logic [4:0]  plen1 = '0;
    logic        en1, flag1, busy1, fin1, err1;
    logic [9:0]  addr1, data1, result1;
    ptm_pkg::state_t st1;
    logic [9:0]  mem1 [0:1023];

    logic        start2 = 1'b0, ovl2 = 1'b0;
    logic [15:0] pat2 = '0;
    logic [4:0]  plen2 = '0;
    logic        en2, flag2, busy2, fin2, err2;
    logic [3:0]  addr2;
    logic [9:0]  data2;
    logic [1:0]  result2;
    ptm_pkg::state_t st2;
    logic [9:0]  mem2 [0:15];

    int checks = 0;
    int failures = 0;

    ptm_param_matcher dut1 (
        .clk(clk), .rst(rst), .start(start1), .pat(pat1), .pat_len(plen1), .overlap(ovl1),
        .en(en1), .addr(addr1), .data(data1), .flag(flag1), .busy(busy1), .fin(fin1),
        .result(result1), .err(err1), .dbg_state(st1)
    );

    ptm_param_matcher #(.ADDR_W(4), .DATA_W(10), .PAT_MAX(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pat(pat2), .pat_len(plen2), .overlap(ovl2),
        .en(en2), .addr(addr2), .data(data2), .flag(flag2), .busy(busy2), .fin(fin2),
        .result(result2), .err(err2), .dbg_state(st2)
    );

    always @(posedge clk) begin
        if (en1) data1 <= mem1[addr1];
        if (en2) data2 <= mem2[addr2];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load1(input string s);
        mem1[0] = 10'(s.len());
        for (int i = 0; i < s.len(); i++) begin
            mem1[i+1] = (s[i] == 8'h31) ? 10'd1 : 10'd0;
        end
    endtask

    task automatic set_in(input int sel, input logic s, input logic [15:0] p, input int len, input logic o);
        if (sel == 1) begin
            start1 = s; pat1 = p; plen1 = 5'(len); ovl1 = o;
        end else begin
            start2 = s; pat2 = p; plen2 = 5'(len); ovl2 = o;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts a run in the current cycle (cycle 0) and follows it to fin, checking timing and totals.
    task automatic run(input int sel, input string tag, input logic [15:0] p, input int len,
                       input logic o, input int poke, input int exp_res, input int exp_flags,
                       input int exp_fin, input int exp_err, input int exp_maxaddr, input int exp_ens);
        int cyc = 0, fin_cyc = -1, flags = 0, maxaddr = 0, ens = 0;
        logic s_en, s_flag, s_fin, s_busy;
        int s_addr, s_res, s_err;
        set_in(sel, 1'b1, p, len, o);
        while (fin_cyc < 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) set_in(sel, 1'b0, p, len, o);
            if (poke > 0 && cyc == poke) set_in(sel, 1'b1, ~p, 0, ~o);
            if (poke > 0 && cyc == poke + 1) set_in(sel, 1'b0, p, len, o);
            s_en   = (sel == 1) ? en1 : en2;
            s_flag = (sel == 1) ? flag1 : flag2;
            s_fin  = (sel == 1) ? fin1 : fin2;
            s_busy = (sel == 1) ? busy1 : busy2;
            s_addr = (sel == 1) ? int'(addr1) : int'(addr2);
            s_res  = (sel == 1) ? int'(result1) : int'(result2);
            s_err  = (sel == 1) ? int'(err1) : int'(err2);
            if (cyc == 1) begin
                chk({tag, "_result_cleared"}, s_res, 0);
                chk({tag, "_busy_c1"}, int'(s_busy), (exp_err != 0) ? 0 : 1);
            end
            if (s_en) begin
                ens++;
                if (s_addr > maxaddr) maxaddr = s_addr;
                chk({tag, "_addr_timing"}, s_addr, (cyc == 1) ? 0 : cyc - 2);
            end
            if (s_flag) flags++;
            if (s_fin) begin
                fin_cyc = cyc;
                chk({tag, "_result"}, s_res, exp_res);
                chk({tag, "_err"}, s_err, exp_err);
                chk({tag, "_busy_at_fin"}, int'(s_busy), 0);
            end
        end
        chk({tag, "_fin_cycle"}, fin_cyc, exp_fin);
        chk({tag, "_flags"}, flags, exp_flags);
        chk({tag, "_max_addr"}, maxaddr, exp_maxaddr);
        chk({tag, "_en_count"}, ens, exp_ens);
    endtask

    initial begin
        int cyc, fins;
        for (int i = 0; i < 1024; i++) mem1[i] = '0;
        for (int i = 0; i < 16; i++) mem2[i] = '0;

        // Reset state
        idle(3);
        chk("rst_en", int'(en1), 0);
        chk("rst_addr", int'(addr1), 0);
        chk("rst_flag", int'(flag1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_fin", int'(fin1), 0);
        chk("rst_result", int'(result1), 0);
        chk("rst_err", int'(err1), 0);
        chk("rst_state", int'(st1), 0);
        rst = 1'b0;
        idle(2);

        // Seven-bit pattern, two overlapping-capable matches in a 13-bit stream
        load1("1101001101001");
        run(1, "p7", 16'b1101001, 7, 1'b1, 0, 2, 2, 19, 0, 13, 14);
        idle(3);

        // 1101 in 1101101: two overlapping matches, one non-overlapping
        load1("1101101");
        run(1, "p4_ovl", 16'b1101, 4, 1'b1, 0, 2, 2, 13, 0, 7, 8);
        idle(2);
        run(1, "p4_novl", 16'b1101, 4, 1'b0, 0, 1, 1, 13, 0, 7, 8);
        idle(2);

        // Illegal pattern lengths: no memory access, immediate fin
        run(1, "len0", 16'hffff, 0, 1'b1, 0, 0, 0, 1, 1, 0, 0);
        run(1, "len17", 16'hffff, 17, 1'b1, 0, 0, 0, 1, 1, 0, 0);
        idle(2);

        // Empty stream
        mem1[0] = 10'd0;
        run(1, "l0", 16'b1, 1, 1'b1, 0, 0, 0, 3, 0, 0, 1);
        idle(2);

        // Small instance: L clamps to 15, single-bit pattern saturates the 2-bit counter
        mem2[0] = 10'd100;
        for (int i = 1; i < 16; i++) mem2[i] = 10'd1;
        run(2, "clamp", 16'b1, 1, 1'b1, 0, 3, 15, 21, 0, 15, 16);
        idle(2);
        mem2[0] = 10'd6;
        run(2, "sat6", 16'b1, 1, 1'b1, 0, 3, 6, 12, 0, 6, 7);
        idle(2);

        // start and input changes while busy are ignored; then a back-to-back start on the fin cycle
        load1("1101101");
        run(1, "poke", 16'b1101, 4, 1'b1, 5, 2, 2, 13, 0, 7, 8);
        run(1, "b2b", 16'b1101, 4, 1'b0, 0, 1, 1, 13, 0, 7, 8);
        idle(3);

        // Asynchronous reset in the middle of a scan
        load1("1101001101001");
        set_in(1, 1'b1, 16'b1101001, 7, 1'b1);
        cyc = 0;
        while (!(en1 && addr1 == 10'd5) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) set_in(1, 1'b0, 16'b1101001, 7, 1'b1);
        end
        chk("mid_reached_addr5", int'(addr1), 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_en", int'(en1), 0);
        chk("mid_rst_addr", int'(addr1), 0);
        chk("mid_rst_busy", int'(busy1), 0);
        chk("mid_rst_fin", int'(fin1), 0);
        chk("mid_rst_result", int'(result1), 0);
        chk("mid_rst_state", int'(st1), 0);
        fins = 0;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (fin1) fins++;
        end
        chk("mid_rst_no_fin", fins, 0);
        chk("mid_rst_idle_state", int'(st1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
